// File: rtl/lab4_sweep_checker.sv
// On-board self-test for the Lab4 2-bit comparator: sweeps all 16 {a1,a0,b1,b0}
// vectors, checks the one-hot RGB response and records error count and first failure.
module lab4_sweep_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a1,
  output logic       a0,
  output logic       b1,
  output logic       b0,
  input  logic       red,
  input  logic       green,
  input  logic       blue,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] first_fail_idx,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [3:0] ffi_q, ffi_d;
  logic       ffv_q, ffv_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic [1:0] a_val, b_val;
  logic [2:0] exp_rgb;
  logic       mismatch;

  always_comb begin
    a_val    = idx_q[3:2];
    b_val    = idx_q[1:0];
    exp_rgb  = {a_val > b_val, a_val == b_val, a_val < b_val};
    // Any deviation, including zero-hot or multi-hot responses, is a failure.
    mismatch = (exp_rgb != {red, green, blue});
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    ffv_d   = ffv_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = '0;
          ffi_d   = '0;
          ffv_d   = 1'b0;
          pass_d  = 1'b0;
          idx_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 5'd1;
          if (!ffv_q) begin
            ffi_d = idx_q;
            ffv_d = 1'b1;
          end
        end
        if (idx_q != 4'hF) begin
          idx_d   = idx_q + 4'd1;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
        end else begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        pass_d  = (err_q == '0);
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      ffi_q   <= '0;
      ffv_q   <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      ffv_q   <= ffv_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign a1               = idx_q[3];
  assign a0               = idx_q[2];
  assign b1               = idx_q[1];
  assign b0               = idx_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_valid = ffv_q;

endmodule

// File: tb/tb_lab4_sweep_checker.sv
// Bench for lab4_sweep_checker: two instances (SETTLE_CYCLES=2 and 1) driving a
// behavioural comparator with selectable faults; a scoreboard holds expected vectors/results.
module tb_lab4_sweep_checker;

  typedef struct {
    logic [4:0] err;
    logic [3:0] ffi;
    logic       ffv;
    logic       pass;
  } res_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start;
  logic [1:0] a1, a0, b1, b0, red, green, blue, busy, done, pass, ffv;
  logic [4:0] errc [2];
  logic [3:0] ffi  [2];
  int         mode;

  int   n_pass  = 0;
  int   n_total = 0;
  int   vec_q[$];
  res_t res_q[$];

  always #5 clk = ~clk;

  lab4_sweep_checker #(.SETTLE_CYCLES(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start[0]),
    .a1(a1[0]), .a0(a0[0]), .b1(b1[0]), .b0(b0[0]),
    .red(red[0]), .green(green[0]), .blue(blue[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(errc[0]), .first_fail_idx(ffi[0]), .first_fail_valid(ffv[0])
  );

  lab4_sweep_checker #(.SETTLE_CYCLES(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start[1]),
    .a1(a1[1]), .a0(a0[1]), .b1(b1[1]), .b0(b0[1]),
    .red(red[1]), .green(green[1]), .blue(blue[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(errc[1]), .first_fail_idx(ffi[1]), .first_fail_valid(ffv[1])
  );

  // Comparator under test: mode 0 correct, 1 red/blue swapped, 2 stuck 000,
  // 3 red=green=1, 4 green dropped only at idx 10.
  function automatic logic [2:0] model(input logic [3:0] v, input int m);
    logic [2:0] e;
    e = {v[3:2] > v[1:0], v[3:2] == v[1:0], v[3:2] < v[1:0]};
    case (m)
      1:       return {e[0], e[1], e[2]};
      2:       return 3'b000;
      3:       return 3'b110;
      4:       return (v == 4'd10) ? (e & 3'b101) : e;
      default: return e;
    endcase
  endfunction

  always_comb {red[0], green[0], blue[0]} = model({a1[0], a0[0], b1[0], b0[0]}, mode);
  always_comb {red[1], green[1], blue[1]} = model({a1[1], a0[1], b1[1], b0[1]}, mode);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 0; i < 2; i++) begin
      n_total++;
      if ({a1[i], a0[i], b1[i], b0[i], busy[i], done[i], pass[i], errc[i], ffi[i], ffv[i]} !== 17'd0) begin
        $display("FAIL %s inst%0d: outputs=%b expected all zero", name, i,
                 {a1[i], a0[i], b1[i], b0[i], busy[i], done[i], pass[i], errc[i], ffi[i], ffv[i]});
      end else n_pass++;
    end
  endtask

  // Full sweep on instance sel (0: S=2, 1: S=1); cycle 0 is the start cycle.
  task automatic run(input int sel, input int m, input bit poke);
    int         s;
    int         d;
    int         dones;
    res_t       r;
    logic [3:0] v;
    logic [2:0] e;
    int         ev;
    res_t       er;
    s     = (sel != 0) ? 1 : 2;
    d     = 16 * (s + 1);
    dones = 0;
    mode  = m;
    r.err = '0; r.ffi = '0; r.ffv = 1'b0;
    for (int k = 0; k < 16; k++) begin
      v = k[3:0];
      vec_q.push_back(k);
      e = {v[3:2] > v[1:0], v[3:2] == v[1:0], v[3:2] < v[1:0]};
      if (e !== model(v, m)) begin
        r.err = r.err + 5'd1;
        if (!r.ffv) begin r.ffi = v; r.ffv = 1'b1; end
      end
    end
    r.pass = (r.err == 5'd0);
    res_q.push_back(r);

    start[sel] = 1'b1;
    tick;
    start[sel] = 1'b0;
    for (int c = 1; c <= d + 2; c++) begin
      n_total++;
      if (busy[sel] !== (c <= d)) $display("FAIL busy m%0d s%0d c%0d: got %b want %b", m, s, c, busy[sel], c <= d);
      else n_pass++;
      n_total++;
      if (done[sel] !== (c == d + 1)) $display("FAIL done m%0d s%0d c%0d: got %b want %b", m, s, c, done[sel], c == d + 1);
      else n_pass++;
      if (done[sel] === 1'b1) dones++;
      if (c == 1) begin
        n_total++;
        if ({pass[sel], errc[sel], ffv[sel]} !== 7'd0)
          $display("FAIL clear_on_start m%0d s%0d: pass/err/ffv=%b want 0", m, s, {pass[sel], errc[sel], ffv[sel]});
        else n_pass++;
      end
      if ((c % (s + 1) == 0) && (c <= d)) begin
        ev = vec_q.pop_front();
        n_total++;
        if ({a1[sel], a0[sel], b1[sel], b0[sel]} !== ev[3:0])
          $display("FAIL vector m%0d s%0d c%0d: got %b want %b", m, s, c, {a1[sel], a0[sel], b1[sel], b0[sel]}, ev[3:0]);
        else n_pass++;
      end
      if (c == d + 2) begin
        er = res_q.pop_front();
        n_total++;
        if (errc[sel] !== er.err) $display("FAIL err_count m%0d s%0d: got %0d want %0d", m, s, errc[sel], er.err);
        else n_pass++;
        n_total++;
        if ({ffv[sel], ffi[sel]} !== {er.ffv, er.ffi})
          $display("FAIL first_fail m%0d s%0d: got v=%b idx=%0d want v=%b idx=%0d", m, s, ffv[sel], ffi[sel], er.ffv, er.ffi);
        else n_pass++;
        n_total++;
        if (pass[sel] !== er.pass) $display("FAIL pass m%0d s%0d: got %b want %b", m, s, pass[sel], er.pass);
        else n_pass++;
        n_total++;
        if ({a1[sel], a0[sel], b1[sel], b0[sel]} !== 4'b0000)
          $display("FAIL vector_idle m%0d s%0d: got %b want 0000", m, s, {a1[sel], a0[sel], b1[sel], b0[sel]});
        else n_pass++;
      end
      start[sel] = poke && ((c == 10) || (c == d + 1));
      tick;
    end
    start[sel] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done[sel] === 1'b1) dones++;
      tick;
    end
    n_total++;
    if (dones != 1) $display("FAIL done_pulses m%0d s%0d: got %0d want 1", m, s, dones);
    else n_pass++;
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = '0;
    mode  = 0;
    repeat (3) tick;
    check_all_zero("reset");
    rst = 1'b0;
    tick;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_correct;
    run(0, 0, 1'b0);
  endtask

  task automatic test_faults;
    run(0, 4, 1'b0);
    run(0, 1, 1'b0);
    run(0, 2, 1'b0);
    run(0, 3, 1'b0);
  endtask

  task automatic test_single_fault_after_pass;
    run(0, 0, 1'b0);
    n_total++;
    if (pass[0] !== 1'b1) $display("FAIL pass_held_before_start: got %b want 1", pass[0]);
    else n_pass++;
    run(0, 4, 1'b0);
  endtask

  task automatic test_ignore_start;
    run(0, 0, 1'b1);
  endtask

  task automatic test_mid_reset;
    mode     = 1;
    start[0] = 1'b1;
    tick;
    start[0] = 1'b0;
    for (int c = 1; c < 20; c++) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check_all_zero("mid_sweep_reset");
    tick;
    run(0, 0, 1'b0);
  endtask

  task automatic test_settle1;
    run(1, 0, 1'b0);
    run(1, 1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_correct;
    test_faults;
    test_single_fault_after_pass;
    test_ignore_start;
    test_mid_reset;
    test_settle1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lab4_sweep_checker.md
Name: lab4_sweep_checker

Overview:
- Self-checking stimulus engine for the Lab4 2-bit comparator (inputs a1,a0,b1,b0; outputs red, green, blue).
- Drives all 16 input combinations in order and waits a settle time for each one.
- Samples the RGB response for each combination and checks it against the comparator contract:
  - green = A==B
  - red = A>B
  - blue = A<B
  - exactly one colour is high.
- Sits on the board beside the Lab4 instance and replaces the simulation bench for on-FPGA self-test. It reports pass/fail, error count and the first failing vector.

Parameters:
SETTLE_CYCLES, 2, cycles each vector is held before sampling; legal range 1..15

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  begin a sweep; accepted only in IDLE
a1  output  1  comparator input A bit 1 (registered)
a0  output  1  comparator input A bit 0 (registered)
b1  output  1  comparator input B bit 1 (registered)
b0  output  1  comparator input B bit 0 (registered)
red  input  1  comparator response, A>B
green  input  1  comparator response, A==B
blue  input  1  comparator response, A<B
busy  output  1  high while a sweep is running
done  output  1  one-cycle pulse when a sweep completes
pass  output  1  sweep result; held until the next accepted start
err_count  output  5  number of failing vectors, 0..16
first_fail_idx  output  4  index {a1,a0,b1,b0} of the first failing vector
first_fail_valid  output  1  first_fail_idx holds a valid value

Behaviour:
- Clocking: one clock, clk. rst is synchronous and active-high.
- Reset: every output is 0 and the state is IDLE. Reset overrides all other activity, including mid-sweep; the partial result is discarded.
- States:
  - IDLE: waits for start.
  - SETTLE: holds the current vector.
  - CHECK: samples the response.
  - DONE: one cycle; asserts done.
- Vector index: 4-bit idx. The driven outputs are {a1,a0,b1,b0} = idx, so A = idx[3:2] and B = idx[1:0].
- IDLE with start=1 at cycle 0:
  - err_count, first_fail_valid, first_fail_idx and pass are cleared.
  - idx becomes 0 and vector 0000 is driven.
  - The settle counter loads SETTLE_CYCLES-1 and the state goes to SETTLE.
- SETTLE: lasts exactly SETTLE_CYCLES cycles (counter down to 0), then goes to CHECK.
- CHECK: lasts one cycle.
  - expected = {A>B, A==B, A<B}, compared with {red, green, blue}.
  - Any mismatch, including zero-hot or multi-hot responses, counts as a fail: err_count increments, and if first_fail_valid=0 then first_fail_idx<=idx and first_fail_valid<=1.
  - If idx<15: idx increments, the new vector is driven on the same edge, the counter reloads and the state returns to SETTLE.
  - If idx==15: the state goes to DONE.
- Vector timing: vector k is sampled in cycle (k+1)*(SETTLE_CYCLES+1).
- DONE:
  - done=1 for exactly one cycle, in cycle 16*(SETTLE_CYCLES+1)+1.
  - pass <= (err_count==0), with err_count including the final CHECK.
  - The driven vector returns to 0000 and the next state is IDLE.
- busy is 1 in SETTLE and CHECK, and 0 in IDLE and DONE.
- start while busy or in DONE is ignored; there is no queuing.
- Result holding: err_count, first_fail_* and pass hold their values after DONE until the next accepted start or rst.
- err_count width: 5 bits, so 16 failures fit without saturation logic.
- Input sampling: red/green/blue are sampled only in CHECK and are ignored in every other state.

Test Plan:
- Correct comparator model, SETTLE_CYCLES=2, start at cycle 0 -> busy during cycles 1..48; done in cycle 49 only; pass=1, err_count=0, first_fail_valid=0.
- Model with red and blue swapped -> err_count=12; first_fail_idx=4'b0001 (A=0, B=1, expected blue); pass=0.
- Outputs stuck at 000 -> err_count=16, first_fail_idx=0, pass=0. Outputs forced to red=green=1 -> err_count=16, first_fail_idx=0, pass=0.
- Single fault, green dropped only for idx 10 (A=B=2) -> err_count=1, first_fail_idx=10, pass=1 before start and 0 after done.
- start pulsed again at cycle 10 and at the done cycle -> both ignored; exactly one done pulse. rst at cycle 20 -> next cycle all outputs 0 and busy=0; a new start gives a clean full run.
- SETTLE_CYCLES=1 with the correct model -> vector k sampled in cycle 2(k+1); done in cycle 33; pass=1.
